rid_restore_stage: RTL and testbench

- Read-response-side stage of the ROB, sitting directly downstream of the ID allocate/restore unit.
- Accepts R beats from the slave carrying the unique ID and queries the allocator's free interface to get the original ID back.
- Forwards each beat to the master with the original ID through a 2-entry skid buffer.
- Issues the free request on each accepted last beat, and drops and flags beats whose unique ID is not outstanding.

---
 rtl/rob_pkg.sv | 16 +
 rtl/rob_skid_buffer.sv | 54 +++++
 rtl/rid_restore_stage.sv | 100 ++++++++++
 tb/tb_rid_restore_stage.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Types and default sizes shared by the ROB stages: the ID allocator and the AR-side and R-side stages.
package rob_pkg;

  localparam int DEF_ID_WIDTH        = 4;
  localparam int DEF_DATA_WIDTH      = 64;
  localparam int DEF_RESP_WIDTH      = 2;
  localparam int DEF_MAX_OUTSTANDING = 16;

  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]   id;
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_RESP_WIDTH-1:0] resp;
    logic                      last;
  } r_beat_t;

endpackage

// File: rtl/rob_skid_buffer.sv
// Two-entry valid/ready FIFO that holds any payload type. in_ready depends only on the fill level,
// so the buffer decouples the ready paths and keeps full throughput.
module rob_skid_buffer #(
  parameter type payload_t = logic [7:0]
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_data
);

  payload_t   mem [2];
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;

  assign in_ready  = (count != 2'd2) & ~rst;
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the storage is reset along with the pointers because the head entry drives the outputs,
  // and those outputs must read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem    <= '{default: '0};
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rid_restore_stage.sv
// This R-channel stage restores each beat's original ID through the allocator's free port.
// It tracks which unique IDs are outstanding, frees an ID on its last beat, and drops beats whose ID is not outstanding.
module rid_restore_stage
  import rob_pkg::*;
#(
  parameter int ID_WIDTH        = DEF_ID_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int RESP_WIDTH      = DEF_RESP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [ID_WIDTH-1:0]   s_rid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [RESP_WIDTH-1:0] s_rresp,
  input  logic                  s_rlast,
  output logic                  m_rvalid,
  input  logic                  m_rready,
  output logic [ID_WIDTH-1:0]   m_rid,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic [RESP_WIDTH-1:0] m_rresp,
  output logic                  m_rlast,
  input  logic                  alloc_gnt,
  input  logic [ID_WIDTH-1:0]   unique_id,
  output logic [ID_WIDTH-1:0]   unique_id_to_free,
  input  logic [ID_WIDTH-1:0]   restored_id,
  output logic                  free_req,
  output logic                  err_unexpected_rid
);

  // Same field layout as rob_pkg::r_beat_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;
  } beat_t;

  logic [MAX_OUTSTANDING-1:0] bitmap;
  logic [MAX_OUTSTANDING-1:0] bitmap_d;
  logic                       accept;
  logic                       hit;
  logic                       valid_beat;
  logic                       err_q;
  beat_t                      push_beat;
  beat_t                      head_beat;

  assign unique_id_to_free = s_rid;
  assign accept            = s_rvalid & s_rready;
  assign hit               = bitmap[s_rid];
  assign valid_beat        = accept & hit;
  assign free_req          = valid_beat & s_rlast;
  assign push_beat         = '{id: restored_id, data: s_rdata, resp: s_rresp, last: s_rlast};

  // Only beats whose ID is outstanding reach the buffer. Unknown IDs are still accepted (s_rready) and then dropped.
  rob_skid_buffer #(
    .payload_t (beat_t)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_rvalid & hit),
    .in_ready  (s_rready),
    .in_data   (push_beat),
    .out_valid (m_rvalid),
    .out_ready (m_rready),
    .out_data  (head_beat)
  );

  assign m_rid   = head_beat.id;
  assign m_rdata = head_beat.data;
  assign m_rresp = head_beat.resp;
  assign m_rlast = head_beat.last;

  // A grant in the same cycle as a free of the same ID re-opens it, so the set is applied last.
  // NOTE: the comb block starts from a full default so no path through it can infer a latch.
  always_comb begin
    bitmap_d = bitmap;
    if (free_req) begin
      bitmap_d[s_rid] = 1'b0;
    end
    if (alloc_gnt) begin
      bitmap_d[unique_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap <= '0;
      err_q  <= 1'b0;
    end else begin
      bitmap <= bitmap_d;
      err_q  <= accept & ~hit;
    end
  end

  assign err_unexpected_rid = err_q;

endmodule

// File: tb/tb_rid_restore_stage.sv
// Bench for rid_restore_stage: directed scenarios plus random traffic. Every cycle is scored against
// a reference model that tracks outstanding IDs in an array and the forwarded beats in a queue.
module tb_rid_restore_stage;

  localparam int IW = 4;
  localparam int DW = 64;
  localparam int RW = 2;
  localparam int NO = 16;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [RW-1:0] resp;
    logic          last;
  } beat_m_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_rvalid = 1'b0;
  logic          s_rready;
  logic [IW-1:0] s_rid = '0;
  logic [DW-1:0] s_rdata = '0;
  logic [RW-1:0] s_rresp = '0;
  logic          s_rlast = 1'b0;
  logic          m_rvalid;
  logic          m_rready = 1'b0;
  logic [IW-1:0] m_rid;
  logic [DW-1:0] m_rdata;
  logic [RW-1:0] m_rresp;
  logic          m_rlast;
  logic          alloc_gnt = 1'b0;
  logic [IW-1:0] unique_id = '0;
  logic [IW-1:0] unique_id_to_free;
  logic [IW-1:0] restored_id;
  logic          free_req;
  logic          err_unexpected_rid;

  // Allocator stand-in: the unique-to-original ID table.
  logic [IW-1:0] orig_of [NO];

  // Reference model state.
  bit      outstanding [NO];
  beat_m_t exp_q [$];
  bit      err_exp;

  int vectors = 0;
  int miscompares = 0;

  assign restored_id = orig_of[unique_id_to_free];

  always #5 clk = ~clk;

  rid_restore_stage dut (
    .clk                (clk),
    .rst                (rst),
    .s_rvalid           (s_rvalid),
    .s_rready           (s_rready),
    .s_rid              (s_rid),
    .s_rdata            (s_rdata),
    .s_rresp            (s_rresp),
    .s_rlast            (s_rlast),
    .m_rvalid           (m_rvalid),
    .m_rready           (m_rready),
    .m_rid              (m_rid),
    .m_rdata            (m_rdata),
    .m_rresp            (m_rresp),
    .m_rlast            (m_rlast),
    .alloc_gnt          (alloc_gnt),
    .unique_id          (unique_id),
    .unique_id_to_free  (unique_id_to_free),
    .restored_id        (restored_id),
    .free_req           (free_req),
    .err_unexpected_rid (err_unexpected_rid)
  );

  task automatic model_clear();
    for (int i = 0; i < NO; i++) outstanding[i] = 1'b0;
    exp_q.delete();
    err_exp = 1'b0;
  endtask

  // Called just after a falling edge with the inputs already driven. Scores the outputs, advances
  // one rising edge and the model with it, then returns at the next falling edge.
  task automatic tick();
    bit exp_rdy, exp_acc, exp_hit, exp_free;
    #1;
    exp_rdy  = !rst && (exp_q.size() < 2);
    exp_acc  = s_rvalid && exp_rdy;
    exp_hit  = outstanding[s_rid];
    exp_free = exp_acc && exp_hit && s_rlast;
    vectors++;
    if (s_rready !== exp_rdy) begin
      miscompares++;
      $display("FAIL s_rready: got %b expected %b at %0t", s_rready, exp_rdy, $time);
    end
    vectors++;
    if (m_rvalid !== (exp_q.size() != 0)) begin
      miscompares++;
      $display("FAIL m_rvalid: got %b expected %b at %0t", m_rvalid, exp_q.size() != 0, $time);
    end
    if (exp_q.size() != 0) begin
      vectors++;
      if (m_rid !== exp_q[0].id || m_rdata !== exp_q[0].data ||
          m_rresp !== exp_q[0].resp || m_rlast !== exp_q[0].last) begin
        miscompares++;
        $display("FAIL m_payload: got id=%h data=%h resp=%h last=%b expected id=%h data=%h resp=%h last=%b at %0t",
                 m_rid, m_rdata, m_rresp, m_rlast, exp_q[0].id, exp_q[0].data, exp_q[0].resp,
                 exp_q[0].last, $time);
      end
    end
    vectors++;
    if (free_req !== exp_free) begin
      miscompares++;
      $display("FAIL free_req: got %b expected %b at %0t", free_req, exp_free, $time);
    end
    vectors++;
    if (err_unexpected_rid !== err_exp) begin
      miscompares++;
      $display("FAIL err_unexpected_rid: got %b expected %b at %0t", err_unexpected_rid, err_exp, $time);
    end
    vectors++;
    if (unique_id_to_free !== s_rid) begin
      miscompares++;
      $display("FAIL unique_id_to_free: got %h expected %h at %0t", unique_id_to_free, s_rid, $time);
    end
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (exp_q.size() != 0 && m_rready) void'(exp_q.pop_front());
      if (exp_acc && exp_hit) exp_q.push_back('{orig_of[s_rid], s_rdata, s_rresp, s_rlast});
      err_exp = exp_acc && !exp_hit;
      if (exp_free) outstanding[s_rid] = 1'b0;
      if (alloc_gnt) outstanding[unique_id] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drive_beat(input logic [IW-1:0] id, input logic [DW-1:0] data, input logic last);
    s_rvalid = 1'b1;
    s_rid    = id;
    s_rdata  = data;
    s_rresp  = RW'($urandom_range(0, 3));
    s_rlast  = last;
  endtask

  task automatic grant(input logic [IW-1:0] uid, input logic [IW-1:0] orig);
    orig_of[uid] = orig;
    alloc_gnt    = 1'b1;
    unique_id    = uid;
    tick();
    alloc_gnt    = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    vectors++;
    if (m_rvalid !== 1'b0 || s_rready !== 1'b0 || free_req !== 1'b0 || err_unexpected_rid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b free=%b err=%b expected all 0",
               m_rvalid, s_rready, free_req, err_unexpected_rid);
    end
    vectors++;
    if (m_rid !== '0 || m_rdata !== '0 || m_rresp !== '0 || m_rlast !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_payload: got id=%h data=%h resp=%h last=%b expected 0",
               m_rid, m_rdata, m_rresp, m_rlast);
    end
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_beat();
    grant(4'd3, 4'd9);
    m_rready = 1'b1;
    drive_beat(4'd3, {$urandom, $urandom}, 1'b1);
    #1;
    vectors++;
    if (free_req !== 1'b1) begin
      miscompares++;
      $display("FAIL t1_free_req: got %b expected 1", free_req);
    end
    tick();
    s_rvalid = 1'b0;
    vectors++;
    if (m_rvalid !== 1'b1 || m_rid !== 4'd9) begin
      miscompares++;
      $display("FAIL t1_forward: got valid=%b id=%h expected valid=1 id=9", m_rvalid, m_rid);
    end
    tick();
    // ID 3 was freed, so a stray beat on it is an error.
    drive_beat(4'd3, {$urandom, $urandom}, 1'b1);
    tick();
    s_rvalid = 1'b0;
    vectors++;
    if (err_unexpected_rid !== 1'b1 || m_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_bitmap_cleared: got err=%b valid=%b expected err=1 valid=0",
               err_unexpected_rid, m_rvalid);
    end
    tick();
  endtask

  task automatic test_burst();
    logic [DW-1:0] d [4];
    grant(4'd5, 4'd2);
    m_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d[i] = {$urandom, $urandom};
      drive_beat(4'd5, d[i], i == 3);
      #1;
      vectors++;
      if (free_req !== (i == 3)) begin
        miscompares++;
        $display("FAIL t2_free_beat%0d: got %b expected %b", i, free_req, i == 3);
      end
      tick();
      vectors++;
      if (m_rvalid !== 1'b1 || m_rid !== 4'd2 || m_rdata !== d[i]) begin
        miscompares++;
        $display("FAIL t2_out_beat%0d: got valid=%b id=%h data=%h expected valid=1 id=2 data=%h",
                 i, m_rvalid, m_rid, m_rdata, d[i]);
      end
    end
    s_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d [3];
    logic [IW-1:0] o;
    o = IW'($urandom_range(0, 15));
    grant(4'd6, o);
    m_rready = 1'b0;
    for (int k = 0; k < 3; k++) d[k] = {$urandom, $urandom};
    for (int k = 0; k < 2; k++) begin
      drive_beat(4'd6, d[k], 1'b0);
      tick();
    end
    drive_beat(4'd6, d[2], 1'b1);
    #1;
    vectors++;
    if (s_rready !== 1'b0) begin
      miscompares++;
      $display("FAIL t3_full: got s_rready=%b expected 0", s_rready);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (m_rvalid !== 1'b1 || m_rdata !== d[0] || m_rid !== o) begin
        miscompares++;
        $display("FAIL t3_stall%0d: got valid=%b id=%h data=%h expected valid=1 id=%h data=%h",
                 k, m_rvalid, m_rid, m_rdata, o, d[0]);
      end
    end
    m_rready = 1'b1;
    tick();
    vectors++;
    if (m_rdata !== d[1]) begin
      miscompares++;
      $display("FAIL t3_drain1: got %h expected %h", m_rdata, d[1]);
    end
    tick();
    s_rvalid = 1'b0;
    vectors++;
    if (m_rvalid !== 1'b1 || m_rdata !== d[2] || m_rlast !== 1'b1) begin
      miscompares++;
      $display("FAIL t3_third: got valid=%b data=%h last=%b expected valid=1 data=%h last=1",
               m_rvalid, m_rdata, m_rlast, d[2]);
    end
    tick();
    vectors++;
    if (m_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL t3_empty: got m_rvalid=%b expected 0", m_rvalid);
    end
  endtask

  task automatic test_unexpected_rid();
    m_rready = 1'b1;
    drive_beat(4'd7, {$urandom, $urandom}, 1'b1);
    #1;
    vectors++;
    if (free_req !== 1'b0 || s_rready !== 1'b1) begin
      miscompares++;
      $display("FAIL t4_accept: got free=%b ready=%b expected free=0 ready=1", free_req, s_rready);
    end
    tick();
    s_rvalid = 1'b0;
    vectors++;
    if (m_rvalid !== 1'b0 || err_unexpected_rid !== 1'b1) begin
      miscompares++;
      $display("FAIL t4_drop: got valid=%b err=%b expected valid=0 err=1", m_rvalid, err_unexpected_rid);
    end
    tick();
    vectors++;
    if (err_unexpected_rid !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_pulse_width: got err=%b expected 0", err_unexpected_rid);
    end
  endtask

  task automatic test_set_wins();
    logic [IW-1:0] o;
    logic [DW-1:0] d;
    o = IW'($urandom_range(0, 15));
    grant(4'd4, o);
    m_rready  = 1'b1;
    drive_beat(4'd4, {$urandom, $urandom}, 1'b1);
    alloc_gnt = 1'b1;
    unique_id = 4'd4;
    #1;
    vectors++;
    if (free_req !== 1'b1) begin
      miscompares++;
      $display("FAIL t5_free: got %b expected 1", free_req);
    end
    tick();
    alloc_gnt = 1'b0;
    d = {$urandom, $urandom};
    drive_beat(4'd4, d, 1'b1);
    tick();
    s_rvalid = 1'b0;
    vectors++;
    if (m_rvalid !== 1'b1 || m_rid !== o || m_rdata !== d || err_unexpected_rid !== 1'b0) begin
      miscompares++;
      $display("FAIL t5_reuse: got valid=%b id=%h data=%h err=%b expected valid=1 id=%h data=%h err=0",
               m_rvalid, m_rid, m_rdata, err_unexpected_rid, o, d);
    end
    tick();
  endtask

  task automatic test_async_reset();
    grant(4'd1, 4'd12);
    m_rready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_beat(4'd1, {$urandom, $urandom}, 1'b0);
      tick();
    end
    drive_beat(4'd1, {$urandom, $urandom}, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    vectors++;
    if (m_rvalid !== 1'b0 || s_rready !== 1'b0 || free_req !== 1'b0) begin
      miscompares++;
      $display("FAIL t6_async: got valid=%b ready=%b free=%b expected all 0", m_rvalid, s_rready, free_req);
    end
    vectors++;
    if (m_rid !== '0 || m_rdata !== '0) begin
      miscompares++;
      $display("FAIL t6_payload: got id=%h data=%h expected 0", m_rid, m_rdata);
    end
    @(negedge clk);
    s_rvalid = 1'b0;
    tick();
    rst = 1'b0;
    m_rready = 1'b1;
    tick();
    // The bitmap was cleared, so ID 1 is no longer outstanding.
    drive_beat(4'd1, {$urandom, $urandom}, 1'b1);
    tick();
    s_rvalid = 1'b0;
    vectors++;
    if (err_unexpected_rid !== 1'b1 || m_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL t6_bitmap: got err=%b valid=%b expected err=1 valid=0", err_unexpected_rid, m_rvalid);
    end
    tick();
  endtask

  task automatic test_random();
    int u;
    for (int c = 0; c < 500; c++) begin
      alloc_gnt = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        u = $urandom_range(0, NO - 1);
        if (!outstanding[u]) begin
          orig_of[u] = IW'($urandom_range(0, 15));
          alloc_gnt  = 1'b1;
          unique_id  = IW'(u);
        end
      end
      s_rvalid = ($urandom_range(0, 2) != 0);
      s_rid    = IW'($urandom_range(0, NO - 1));
      s_rdata  = {$urandom, $urandom};
      s_rresp  = RW'($urandom_range(0, 3));
      s_rlast  = ($urandom_range(0, 3) == 0);
      m_rready = ($urandom_range(0, 3) != 0);
      tick();
    end
    alloc_gnt = 1'b0;
    s_rvalid  = 1'b0;
    m_rready  = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < NO; i++) orig_of[i] = '0;
    model_clear();
    test_reset();
    test_single_beat();
    test_burst();
    test_back_to_back();
    test_unexpected_rid();
    test_set_wins();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
